// File: rtl/cordic_pkg.sv
// Shared constants for the CORDIC result path (core, result FIFO, AHB-Lite bridge).
package cordic_pkg;
  localparam int          CORDIC_WIDTH       = 32;
  localparam int          CORDIC_FIFO_DEPTH  = 16;
  localparam logic [31:0] CORDIC_RESULT_ADDR = 32'h4001_0000;
  localparam logic [31:0] CORDIC_STATUS_ADDR = 32'h4001_0004;

  typedef logic [CORDIC_WIDTH-1:0] cordic_word_t;
endpackage

// File: rtl/cordic_result_fifo_if.sv
// Handshake bundle between the CORDIC core/bridge (master) and the result FIFO (slave).
interface cordic_result_fifo_if
  import cordic_pkg::*;
#(
  parameter int WIDTH = CORDIC_WIDTH,
  parameter int DEPTH = CORDIC_FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
);
  logic             valid_out_interface;
  logic [WIDTH-1:0] cordic_result;
  logic             clr;
  logic             read_fifo_en;
  logic [WIDTH-1:0] out_fifo;
  logic             empty;
  logic             full;
  logic [AW:0]      level;
  logic             overflow;
  logic             underflow;

  modport master (
    output valid_out_interface, cordic_result, clr, read_fifo_en,
    input  out_fifo, empty, full, level, overflow, underflow
  );

  modport slave (
    input  valid_out_interface, cordic_result, clr, read_fifo_en,
    output out_fifo, empty, full, level, overflow, underflow
  );
endinterface

// File: rtl/cordic_fifo_mem.sv
// Register-array storage: one synchronous write port, one asynchronous read port.
module cordic_fifo_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  // Deliberately unreset: contents are only observable through the empty-gated head.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/cordic_result_fifo.sv
// First-word-fall-through result queue with sticky overflow/underflow and sync flush.
module cordic_result_fifo
  import cordic_pkg::*;
#(
  parameter int WIDTH = CORDIC_WIDTH,
  parameter int DEPTH = CORDIC_FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  cordic_result_fifo_if.slave  fif
);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      level;
  logic             overflow, underflow;
  logic             empty, full;
  logic             wr_en, rd_en;
  logic             ovf_set, udf_set;
  logic [WIDTH-1:0] head;

  assign empty = (level == '0);
  assign full  = (level == FULL_LVL);

  // A pop frees the slot in the same edge, so a write into a full queue is legal if paired with one.
  assign wr_en   = fif.valid_out_interface && (!full || fif.read_fifo_en) && !fif.clr;
  assign rd_en   = fif.read_fifo_en && !empty && !fif.clr;
  assign ovf_set = fif.valid_out_interface && full && !fif.read_fifo_en;
  assign udf_set = fif.read_fifo_en && empty;

  cordic_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (HCLK),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (fif.cordic_result),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (fif.clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (ovf_set) overflow  <= 1'b1;
      if (udf_set) underflow <= 1'b1;
    end
  end

  assign fif.out_fifo  = empty ? '0 : head;
  assign fif.empty     = empty;
  assign fif.full      = full;
  assign fif.level     = level;
  assign fif.overflow  = overflow;
  assign fif.underflow = underflow;
endmodule

// File: tb/tb_cordic_result_fifo.sv
// Scoreboard bench for cordic_result_fifo: directed scenarios plus random push/pop traffic.
module tb_cordic_result_fifo;
  localparam int WIDTH = 32;
  localparam int DEPTH = 16;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  int   tests = 0;
  int   fails = 0;
  logic [WIDTH-1:0] sb [$];
  logic [WIDTH-1:0] exp_w;

  always #5 HCLK = ~HCLK;

  cordic_result_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) fif ();

  cordic_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .fif     (fif)
  );

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_inputs();
    fif.valid_out_interface = 1'b0;
    fif.cordic_result       = '0;
    fif.clr                 = 1'b0;
    fif.read_fifo_en        = 1'b0;
  endtask

  task automatic do_write(input logic [WIDTH-1:0] d, input bit expect_accept);
    fif.valid_out_interface = 1'b1;
    fif.cordic_result       = d;
    if (expect_accept) sb.push_back(d);
    step();
    fif.valid_out_interface = 1'b0;
  endtask

  task automatic do_pop(input string name);
    exp_w = sb.pop_front();
    tests++;
    if (fif.out_fifo !== exp_w) begin
      fails++;
      $display("FAIL %s head: got %h want %h", name, fif.out_fifo, exp_w);
    end
    fif.read_fifo_en = 1'b1;
    step();
    fif.read_fifo_en = 1'b0;
  endtask

  task automatic do_clr();
    fif.clr = 1'b1;
    step();
    fif.clr = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    idle_inputs();
    HRESETn = 1'b0;
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    step();
    tests++; if (fif.empty !== 1'b1) begin fails++; $display("FAIL reset_empty got %b want 1", fif.empty); end
    tests++; if (fif.full !== 1'b0) begin fails++; $display("FAIL reset_full got %b want 0", fif.full); end
    tests++; if (fif.level !== 5'd0) begin fails++; $display("FAIL reset_level got %0d want 0", fif.level); end
    tests++; if (fif.out_fifo !== 32'h0) begin fails++; $display("FAIL reset_out got %h want 0", fif.out_fifo); end
    tests++; if (fif.overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b want 0", fif.overflow); end
    tests++; if (fif.underflow !== 1'b0) begin fails++; $display("FAIL reset_udf got %b want 0", fif.underflow); end
  endtask

  task automatic test_order_wrap();
    for (int r = 0; r < 20; r++) begin
      for (int i = 1; i <= 3; i++) do_write(32'(i), 1'b1);
      tests++; if (fif.level !== 5'd3) begin fails++; $display("FAIL wrap_level r=%0d got %0d want 3", r, fif.level); end
      for (int i = 0; i < 3; i++) do_pop("order");
      tests++; if (fif.empty !== 1'b1) begin fails++; $display("FAIL wrap_empty r=%0d got %b want 1", r, fif.empty); end
      tests++; if (fif.out_fifo !== 32'h0) begin fails++; $display("FAIL wrap_out0 r=%0d got %h want 0", r, fif.out_fifo); end
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) do_write(32'hA0 + 32'(i), 1'b1);
    tests++; if (fif.full !== 1'b1) begin fails++; $display("FAIL ovf_full_pre got %b want 1", fif.full); end
    tests++; if (fif.overflow !== 1'b0) begin fails++; $display("FAIL ovf_early got %b want 0", fif.overflow); end
    do_write(32'hBB, 1'b0);
    tests++; if (fif.full !== 1'b1) begin fails++; $display("FAIL ovf_full got %b want 1", fif.full); end
    tests++; if (fif.overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag got %b want 1", fif.overflow); end
    tests++; if (fif.level !== 5'd16) begin fails++; $display("FAIL ovf_level got %0d want 16", fif.level); end
    for (int i = 0; i < DEPTH; i++) do_pop("ovf_drain");
    tests++; if (fif.empty !== 1'b1) begin fails++; $display("FAIL ovf_drain_empty got %b want 1", fif.empty); end
    tests++; if (fif.overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky got %b want 1", fif.overflow); end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < DEPTH; i++) do_write(32'hA0 + 32'(i), 1'b1);
    exp_w = sb.pop_front();
    tests++; if (fif.out_fifo !== exp_w) begin fails++; $display("FAIL frw_head got %h want %h", fif.out_fifo, exp_w); end
    sb.push_back(32'hCC);
    fif.valid_out_interface = 1'b1;
    fif.cordic_result       = 32'hCC;
    fif.read_fifo_en        = 1'b1;
    step();
    idle_inputs();
    tests++; if (fif.level !== 5'd16) begin fails++; $display("FAIL frw_level got %0d want 16", fif.level); end
    tests++; if (fif.full !== 1'b1) begin fails++; $display("FAIL frw_full got %b want 1", fif.full); end
    tests++; if (fif.out_fifo !== 32'hA1) begin fails++; $display("FAIL frw_adv got %h want a1", fif.out_fifo); end
    for (int i = 0; i < DEPTH; i++) do_pop("frw_drain");
    tests++; if (fif.empty !== 1'b1) begin fails++; $display("FAIL frw_empty got %b want 1", fif.empty); end
  endtask

  task automatic test_underflow();
    do_clr();
    tests++; if (fif.overflow !== 1'b0) begin fails++; $display("FAIL clr_ovf got %b want 0", fif.overflow); end
    fif.read_fifo_en        = 1'b1;
    fif.valid_out_interface = 1'b1;
    fif.cordic_result       = 32'h55;
    sb.push_back(32'h55);
    step();
    idle_inputs();
    tests++; if (fif.underflow !== 1'b1) begin fails++; $display("FAIL udf_flag got %b want 1", fif.underflow); end
    tests++; if (fif.level !== 5'd1) begin fails++; $display("FAIL udf_level got %0d want 1", fif.level); end
    do_pop("udf_head");
    tests++; if (fif.underflow !== 1'b1) begin fails++; $display("FAIL udf_sticky got %b want 1", fif.underflow); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) do_write(32'h300 + 32'(i), 1'b1);
    tests++; if (fif.level !== 5'd5) begin fails++; $display("FAIL fl_pre got %0d want 5", fif.level); end
    fif.clr                 = 1'b1;
    fif.valid_out_interface = 1'b1;
    fif.cordic_result       = 32'h77;
    fif.read_fifo_en        = 1'b1;
    step();
    idle_inputs();
    sb.delete();
    tests++; if (fif.level !== 5'd0) begin fails++; $display("FAIL fl_level got %0d want 0", fif.level); end
    tests++; if (fif.empty !== 1'b1) begin fails++; $display("FAIL fl_empty got %b want 1", fif.empty); end
    tests++; if (fif.underflow !== 1'b0) begin fails++; $display("FAIL fl_udf got %b want 0", fif.underflow); end
    tests++; if (fif.out_fifo !== 32'h0) begin fails++; $display("FAIL fl_out got %h want 0", fif.out_fifo); end
    do_write(32'h99, 1'b1);
    do_pop("fl_after");
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) do_write(32'h400 + 32'(i), 1'b1);
    fif.valid_out_interface = 1'b1;
    fif.cordic_result       = 32'h4FF;
    #2 HRESETn = 1'b0;
    #1;
    tests++; if (fif.level !== 5'd0) begin fails++; $display("FAIL ar_level got %0d want 0", fif.level); end
    tests++; if (fif.empty !== 1'b1) begin fails++; $display("FAIL ar_empty got %b want 1", fif.empty); end
    tests++; if (fif.out_fifo !== 32'h0) begin fails++; $display("FAIL ar_out got %h want 0", fif.out_fifo); end
    tests++; if (fif.full !== 1'b0) begin fails++; $display("FAIL ar_full got %b want 0", fif.full); end
    idle_inputs();
    sb.delete();
    step();
    HRESETn = 1'b1;
    step();
    tests++; if (fif.empty !== 1'b1) begin fails++; $display("FAIL ar_post got %b want 1", fif.empty); end
  endtask

  task automatic test_back_to_back();
    bit wr, rd, was_full, popped, wrote;
    for (int c = 0; c < 400; c++) begin
      wr = ($urandom_range(0, 99) < 60);
      rd = ($urandom_range(0, 99) < 45);
      exp_w = (sb.size() == 0) ? '0 : sb[0];
      tests++; if (fif.out_fifo !== exp_w) begin fails++; $display("FAIL b2b_head c=%0d got %h want %h", c, fif.out_fifo, exp_w); end
      tests++; if (fif.level !== 5'(sb.size())) begin fails++; $display("FAIL b2b_level c=%0d got %0d want %0d", c, fif.level, sb.size()); end
      was_full = (sb.size() == DEPTH);
      popped   = rd && (sb.size() != 0);
      wrote    = wr && (!was_full || rd);
      fif.valid_out_interface = wr;
      fif.cordic_result       = $urandom;
      fif.read_fifo_en        = rd;
      if (popped) void'(sb.pop_front());
      if (wrote)  sb.push_back(fif.cordic_result);
      step();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_order_wrap();
    test_overflow();
    test_full_rw();
    test_underflow();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
